// File: rtl/full_adder.sv
// One-bit full adder; the bit cell that every slice ripple chain is built from.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder_adder_slice.sv
// CHUNK-bit combinational ripple adder for one pipeline slice, built from full_adder cells.
// Also exposes the carry into its top bit so the final slice can derive signed overflow.
module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout    = carry[CHUNK];
    assign msb_cin = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: one CHUNK-bit slice resolved per stage, carry registered between
// stages, valid/ready handshake with a global stall whenever the output is held by backpressure.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iCarry,
    input  logic             iSub,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oSum,
    output logic             oCarry,
    output logic             oOverflow
);

    localparam int CHUNK = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= WIDTH",
               WIDTH, STAGES);
    end

    logic adv;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] carry_d;
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];

    logic [CHUNK-1:0]  slice_sum  [STAGES];
    logic [STAGES-1:0] slice_cout;
    logic              slice_msb  [STAGES];

    assign adv    = ~valid_q[STAGES-1] | iReady;
    assign oReady = adv;

    // Operand skew registers shift right by one slice per stage, so every stage consumes the low
    // CHUNK bits; result slices enter at the top and shift down, landing in place after STAGES.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic             cin_in;
        logic             valid_in;

        if (k == 0) begin : g_first
            assign a_in     = iA;
            assign b_in     = iSub ? ~iB : iB;
            assign cin_in   = iSub | iCarry;
            assign sum_in   = '0;
            assign valid_in = iValid;
        end else begin : g_next
            assign a_in     = a_q[k-1];
            assign b_in     = b_q[k-1];
            assign cin_in   = carry_q[k-1];
            assign sum_in   = sum_q[k-1];
            assign valid_in = valid_q[k-1];
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a       (a_in[CHUNK-1:0]),
            .b       (b_in[CHUNK-1:0]),
            .cin     (cin_in),
            .sum     (slice_sum[k]),
            .cout    (slice_cout[k]),
            .msb_cin (slice_msb[k])
        );

        assign valid_d[k] = valid_in;
        assign carry_d[k] = slice_cout[k];
        assign a_d[k]     = a_in >> CHUNK;
        assign b_d[k]     = b_in >> CHUNK;
        assign sum_d[k]   = (sum_in >> CHUNK) | (WIDTH'(slice_sum[k]) << (WIDTH - CHUNK));
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= slice_cout[STAGES-1] ^ slice_msb[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

    assign oValid    = valid_q[STAGES-1];
    assign oSum      = sum_q[STAGES-1];
    assign oCarry    = carry_q[STAGES-1];
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: directed vectors and corner sequences on an 8-bit/2-stage instance,
// randomised scoreboard traffic on a 32-bit/4-stage instance.
module tb_pipelined_adder;

    localparam int W8  = 8;
    localparam int S8  = 2;
    localparam int W32 = 32;
    localparam int S32 = 4;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8_n  = 1'b1;
    logic rst32_n = 1'b1;

    logic         valid8 = 1'b0, ready8 = 1'b1, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0]   a8 = '0, b8 = '0;
    logic         oready8, ovalid8, ocarry8, oovf8;
    logic [7:0]   osum8;

    logic         valid32 = 1'b0, ready32 = 1'b1, cin32 = 1'b0, sub32 = 1'b0;
    logic [31:0]  a32 = '0, b32 = '0;
    logic         oready32, ovalid32, ocarry32, oovf32;
    logic [31:0]  osum32;

    exp_t q8[$];
    exp_t q32[$];
    exp_t cur8, cur32;

    int checks   = 0;
    int failures = 0;
    int pops32   = 0;

    vec_t vecs[10];

    pipelined_adder #(.WIDTH(W8), .STAGES(S8)) u_dut8 (
        .iClk      (clk),
        .iRst_n    (rst8_n),
        .iValid    (valid8),
        .oReady    (oready8),
        .iA        (a8),
        .iB        (b8),
        .iCarry    (cin8),
        .iSub      (sub8),
        .oValid    (ovalid8),
        .iReady    (ready8),
        .oSum      (osum8),
        .oCarry    (ocarry8),
        .oOverflow (oovf8)
    );

    pipelined_adder #(.WIDTH(W32), .STAGES(S32)) u_dut32 (
        .iClk      (clk),
        .iRst_n    (rst32_n),
        .iValid    (valid32),
        .oReady    (oready32),
        .iA        (a32),
        .iB        (b32),
        .iCarry    (cin32),
        .iSub      (sub32),
        .oValid    (ovalid32),
        .iReady    (ready32),
        .oSum      (osum32),
        .oCarry    (ocarry32),
        .oOverflow (oovf32)
    );

    function automatic exp_t ref_add(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub, input int w);
        logic [63:0] mask, bb, full;
        exp_t r;
        mask    = (64'd1 << w) - 64'd1;
        bb      = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
        full    = ({32'd0, a} & mask) + bb + (sub ? 64'd1 : {63'd0, cin});
        r.sum   = full[31:0] & mask[31:0];
        r.carry = full[w];
        r.ovf   = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs are popped before inputs are pushed so a spurious output can never match the
    // beat accepted in the same cycle.
    always @(negedge clk) begin
        if (rst8_n) begin
            if (ovalid8 && ready8) begin
                if (q8.size() == 0) begin
                    check_output("out8_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    check_output("out8 {carry,ovf,sum}", {54'd0, ocarry8, oovf8, osum8},
                                 {54'd0, e.carry, e.ovf, e.sum[7:0]});
                end
            end
            if (valid8 && oready8) q8.push_back(cur8);
        end
    end

    always @(negedge clk) begin
        if (rst32_n) begin
            if (ovalid32 && ready32) begin
                if (q32.size() == 0) begin
                    check_output("out32_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q32.pop_front();
                    check_output("out32 {carry,ovf,sum}", {30'd0, ocarry32, oovf32, osum32},
                                 {30'd0, e.carry, e.ovf, e.sum});
                    pops32++;
                end
            end
            if (valid32 && oready32) q32.push_back(cur32);
        end
    end

    task automatic apply_stimulus8(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        a8     = a;
        b8     = b;
        cin8   = cin;
        sub8   = sub;
        valid8 = 1'b1;
        cur8   = ref_add({24'd0, a}, {24'd0, b}, cin, sub, W8);
    endtask

    task automatic latency_beat8(input logic [7:0] a, input logic [7:0] b, input string name);
        int n;
        @(posedge clk); #1;
        ready8 = 1'b1;
        apply_stimulus8(a, b, 1'b0, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #1;
            valid8 = 1'b0;
            n++;
        end while (!ovalid8 && n < 20);
        check_output(name, 64'(n), 64'(S8));
        repeat (2) @(posedge clk);
    endtask

    task automatic drain8(input string name);
        int n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check_output(name, 64'(q8.size()), 64'd0);
    endtask

    task automatic drain32(input string name);
        int n = 0;
        while (q32.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check_output(name, 64'(q32.size()), 64'd0);
    endtask

    initial begin
        logic [9:0] held;
        int sent, cyc, pre, stalls, acc32;

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[4] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[5] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

        #2;
        rst8_n  = 1'b0;
        rst32_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid8", 64'(ovalid8), 64'd0);
        check_output("rst_sum8", 64'(osum8), 64'd0);
        check_output("rst_carry8", 64'(ocarry8), 64'd0);
        check_output("rst_ovf8", 64'(oovf8), 64'd0);
        check_output("rst_ready8", 64'(oready8), 64'd1);
        check_output("rst_valid32", 64'(ovalid32), 64'd0);
        check_output("rst_ready32", 64'(oready32), 64'd1);
        rst8_n  = 1'b1;
        rst32_n = 1'b1;

        latency_beat8(8'h7F, 8'h01, "latency8_first");

        // Directed vectors streamed back to back; expectations come straight from the table.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            apply_stimulus8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            cur8 = '{sum: {24'd0, vecs[i].sum}, carry: vecs[i].carry, ovf: vecs[i].ovf};
        end
        @(posedge clk); #1;
        valid8 = 1'b0;
        drain8("drain8_vectors");

        // Six beats with iReady low for cycles 3..5.
        sent = 0;
        cyc  = 0;
        while (sent < 6 && cyc < 40) begin
            @(posedge clk); #1;
            ready8 = !(cyc >= 3 && cyc < 6);
            apply_stimulus8(8'(sent * 37 + 5), 8'(sent * 11 + 3), sent[1], sent[0]);
            @(negedge clk);
            if (cyc == 3) begin
                held = {ocarry8, oovf8, osum8};
                check_output("bp_valid_at_stall", 64'(ovalid8), 64'd1);
            end
            if (cyc >= 3 && cyc < 6) check_output("bp_ready_low", 64'(oready8), 64'd0);
            if (cyc == 4 || cyc == 5)
                check_output("bp_held_out", {54'd0, ocarry8, oovf8, osum8}, {54'd0, held});
            if (oready8) sent++;
            cyc++;
        end
        @(posedge clk); #1;
        valid8 = 1'b0;
        ready8 = 1'b1;
        check_output("bp_sent", 64'(sent), 64'd6);
        drain8("drain8_backpressure");

        // Two beats in flight, then an asynchronous reset pulse between clock edges.
        @(posedge clk); #1;
        apply_stimulus8(8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        apply_stimulus8(8'h21, 8'h13, 1'b0, 1'b0);
        @(posedge clk); #1;
        valid8 = 1'b0;
        check_output("pre_rst_valid8", 64'(ovalid8), 64'd1);
        #1;
        rst8_n = 1'b0;
        q8.delete();
        #1;
        check_output("mid_rst_valid8", 64'(ovalid8), 64'd0);
        check_output("mid_rst_sum8", 64'(osum8), 64'd0);
        check_output("mid_rst_ready8", 64'(oready8), 64'd1);
        #1;
        rst8_n = 1'b1;
        latency_beat8(8'h0F, 8'h01, "latency8_after_rst");
        repeat (4) @(posedge clk);
        check_output("post_rst_queue8", 64'(q8.size()), 64'd0);

        // Throughput window on the 32-bit unit: empty pipe, iReady held high.
        pre    = pops32;
        stalls = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            ready32 = 1'b1;
            valid32 = 1'b1;
            a32     = $urandom;
            b32     = $urandom;
            cin32   = 1'($urandom_range(0, 1));
            sub32   = 1'($urandom_range(0, 1));
            cur32   = ref_add(a32, b32, cin32, sub32, W32);
            @(negedge clk);
            if (!oready32) stalls++;
        end
        @(posedge clk); #1;
        valid32 = 1'b0;
        check_output("tput_stalls", 64'(stalls), 64'd0);
        check_output("tput_outputs", 64'(pops32 - pre), 64'(200 - S32));
        drain32("drain32_tput");

        // Random valid/ready traffic.
        acc32 = 0;
        cyc   = 0;
        while (acc32 < 10000 && cyc < 40000) begin
            @(posedge clk); #1;
            valid32 = ($urandom_range(0, 3) != 0);
            ready32 = ($urandom_range(0, 3) != 0);
            a32     = $urandom;
            b32     = $urandom;
            cin32   = 1'($urandom_range(0, 1));
            sub32   = 1'($urandom_range(0, 1));
            cur32   = ref_add(a32, b32, cin32, sub32, W32);
            @(negedge clk);
            if (valid32 && oready32) acc32++;
            cyc++;
        end
        @(posedge clk); #1;
        valid32 = 1'b0;
        ready32 = 1'b1;
        check_output("rand_beats_accepted", 64'(acc32 >= 10000), 64'd1);
        drain32("drain32_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit: WIDTH-bit operands split into STAGES equal slices, one slice resolved per cycle, carry registered between slices.
- Successor to the single-bit combinational full adder; it is the arithmetic datapath primitive for wide operands at high clock rates.
- Valid/ready handshake on both sides with full-pipeline stall under output backpressure.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth = number of slices; 1 ≤ STAGES ≤ WIDTH.

Ports:
- iClk  input  1  clock, all state on rising edge
- iRst_n  input  1  asynchronous, active-low reset
- iValid  input  1  operand beat valid
- oReady  output  1  unit accepts a beat this cycle
- iA  input  WIDTH  operand A, unsigned/two's complement
- iB  input  WIDTH  operand B
- iCarry  input  1  carry-in (add mode only)
- iSub  input  1  1 = A - B, 0 = A + B + iCarry
- oValid  output  1  result valid
- iReady  input  1  downstream accepts result
- oSum  output  WIDTH  result
- oCarry  output  1  carry-out of MSB (in sub mode: 1 = no borrow)
- oOverflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- CHUNK = WIDTH/STAGES. Slice k covers bits [k*CHUNK +: CHUNK] and is added in stage k.
- Sub mode: B is inverted and carry-in is forced to 1, so iCarry is ignored. Inversion is applied at capture.
- Advance enable: adv = ~oValid | iReady. oReady = adv, combinational; there is no combinational path from iValid to oReady.
- When adv = 1, every stage register loads from its predecessor. Stage 0 loads iValid together with the operands.
- When adv = 0, all registers hold and the pipeline stalls globally. Bubbles are not compressed.
- Beat accepted when iValid & oReady. Latency is exactly STAGES cycles from acceptance to oValid, absent stalls.
- Each stage registers:
  - valid bit;
  - carry out of its slice;
  - result slices computed so far;
  - unconsumed upper operand slices (skew registers);
  - for the final stage, the carry into the MSB for overflow.
- Outputs (oSum, oCarry, oOverflow) are registered. They are held stable while oValid & ~iReady.
- Data registers load even when the corresponding valid bit is 0. Outputs are don't-care when oValid = 0, but must not be X after reset.
- Reset (asserted at any time, including mid-flight): all valid bits = 0 immediately and all data registers = 0. The outputs are therefore oValid = 0, oSum = 0, oCarry = 0, oOverflow = 0, and oReady = 1. In-flight beats are discarded. The first beat after deassertion behaves as if the pipe were empty.
- Wrap-around: sum is modulo 2^WIDTH; the carry-out is reported on oCarry, never dropped silently.
- STAGES = 1: a single registered ripple adder with latency 1; same handshake.
- Simultaneous input accept and output drain in the same cycle is legal. Full throughput is 1 beat/cycle while iReady = 1.

Decomposition:
- Sub-module adder_slice: CHUNK-bit combinational ripple chain built by instantiating the existing full_adder per bit. It exposes its slice carry-out and its MSB carry-in, the latter used for overflow.
- No shared package is needed. CHUNK is a localparam. Parameter legality (WIDTH % STAGES == 0) is checked by a generate-time error block.
- pipelined_adder owns the stage registers, skew registers and handshake, using a generate loop over STAGES.

Test Plan:
- WIDTH=8, STAGES=2, add: A=0x7F, B=0x01, iCarry=0, iReady=1 -> 2 cycles later oSum=0x80, oCarry=0, oOverflow=1.
- Sub mode: A=0x05, B=0x07 -> oSum=0xFE, oCarry=0 (borrow), oOverflow=0. Second case A=0x80, B=0x01 -> oSum=0x7F, oCarry=1, oOverflow=1.
- Wrap-around: A=0xFF, B=0x01, iCarry=1 -> oSum=0x01, oCarry=1. Also, a carry crossing the slice boundary (A=0x0F, B=0x01) -> oSum=0x10.
- Backpressure: stream 6 beats back-to-back and hold iReady=0 for 3 cycles mid-stream. Required: oReady=0 during the stall, outputs held stable, no beat lost or duplicated, order preserved.
- Reset mid-flight: accept 2 beats, then pulse iRst_n low between clock edges. Required: oValid=0 and oSum=0 immediately, oReady=1; the next beat emerges after exactly STAGES cycles.
- Randomised WIDTH=32, STAGES=4, with random iValid/iReady: a scoreboard compares against a reference (A±B+carry) for ≥10k beats, with throughput of 1 beat/cycle when iReady is held at 1.
